// File: rtl/hack_cpu_if.sv
// Hack CPU memory-side bus: instruction ROM fetch port plus data RAM/MMIO port.
// Latency: purely combinational signals; the CPU samples them on its clock edge.
// Backpressure: mem_ready low holds the current data access until it completes.
interface hack_cpu_if #(
  parameter int PC_WIDTH = 15
);
  // Instruction fetch: instr is the ROM word at address pc, valid in the same cycle.
  logic [15:0]         instr;
  logic [PC_WIDTH-1:0] pc;

  // Data access: inM is valid combinationally for addressM; mem_ready completes it.
  logic [15:0]         inM;
  logic                mem_ready;
  logic [PC_WIDTH-1:0] addressM;
  logic [15:0]         outM;
  logic                writeM;
  logic                readM;

  // CPU side.
  modport master (
    input  instr, inM, mem_ready,
    output pc, addressM, outM, writeM, readM
  );

  // Memory side.
  modport slave (
    output instr, inM, mem_ready,
    input  pc, addressM, outM, writeM, readM
  );
endinterface

// File: rtl/hack_cpu.sv
// Hack CPU core (A, D, PC registers around the c_ALU datapath); optional tight-loop
// halt detection is enabled by defining HACK_HALT_DETECT_EN.
// Latency: one instruction per cycle; a data access stalls while mem_ready is low.

// Hack ALU: zero/negate each operand, add or AND, optionally negate the result.
// Latency: combinational.
// Backpressure: none.
module c_ALU (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  // Operand conditioning, function select and output negation.
  always_comb begin
    x_z   = zx ? 16'h0000 : x;
    x_n   = nx ? ~x_z : x_z;
    y_z   = zy ? 16'h0000 : y;
    y_n   = ny ? ~y_z : y_z;
    f_out = f ? (x_n + y_n) : (x_n & y_n);
    out   = no ? ~f_out : f_out;
    zr    = (out == 16'h0000);
    ng    = out[15];
  end
endmodule

// Hack CPU core: fetch/decode/execute of the 16-bit Hack ISA.
// Latency: single-cycle commit; strobes and address are combinational from instr and A.
// Backpressure: readM/writeM with mem_ready low stalls all state; ce low freezes the core.
module hack_cpu #(
  parameter int PC_WIDTH = 15,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  hack_cpu_if.master        bus,
  output logic [15:0]       a_reg,
  output logic [15:0]       d_reg,
  output logic              halted
);
  localparam logic [PC_WIDTH-1:0] RST_PC  = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

  // Architectural state.
  logic [15:0]         a_q;
  logic [15:0]         d_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                halt_q;

  // Decoded instruction fields.
  logic                is_c;
  logic                a_sel;
  logic                dst_a, dst_d, dst_m;
  logic                j_lt, j_eq, j_gt;

  // Datapath.
  logic [15:0]         alu_y;
  logic [15:0]         alu_out;
  logic                alu_zr;
  logic                alu_ng;

  // Control.
  logic                active;
  logic                rd_stb;
  logic                wr_stb;
  logic                stall;
  logic                commit;
  logic                take;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_nxt;

  // Bits 14:13 of a C-instruction carry no meaning.
  logic                unused_bits;
  assign unused_bits = &{1'b0, bus.instr[14:13]};

  // Field decode of the current instruction word.
  always_comb begin
    is_c  = bus.instr[15];
    a_sel = bus.instr[12];
    dst_a = bus.instr[5];
    dst_d = bus.instr[4];
    dst_m = bus.instr[3];
    j_lt  = bus.instr[2];
    j_eq  = bus.instr[1];
    j_gt  = bus.instr[0];
  end

  // ALU y operand: memory when the a-bit is set, otherwise the A register.
  always_comb begin
    alu_y = a_sel ? bus.inM : a_q;
  end

  c_ALU u_alu (
    .x   (d_q),
    .y   (alu_y),
    .zx  (bus.instr[11]),
    .nx  (bus.instr[10]),
    .zy  (bus.instr[9]),
    .ny  (bus.instr[8]),
    .f   (bus.instr[7]),
    .no  (bus.instr[6]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  // Strobes, stall and next-pc selection; reset forces the strobes low immediately.
  always_comb begin
    active = ce & ~halt_q;
    rd_stb = reset_n & active & is_c & a_sel;
    wr_stb = reset_n & active & is_c & dst_m;
    stall  = (rd_stb | wr_stb) & ~bus.mem_ready;
    commit = active & ~stall;
    take   = is_c & ((j_lt & alu_ng) | (j_eq & alu_zr) | (j_gt & ~alu_ng & ~alu_zr));
    pc_inc = pc_q + PC_ONE;
    // Jump target is the A value before any same-cycle A update.
    pc_nxt = take ? a_q[PC_WIDTH-1:0] : pc_inc;
  end

  // Register update: one commit per instruction, held while stalled or disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= RST_PC;
    end else if (commit) begin
      if (!is_c) begin
        a_q <= {1'b0, bus.instr[14:0]};
      end else begin
        if (dst_a) a_q <= alu_out;
        if (dst_d) d_q <= alu_out;
      end
      pc_q <= pc_nxt;
    end
  end

`ifdef HACK_HALT_DETECT_EN
  logic                prev_was_a_vld;
  logic [PC_WIDTH-1:0] prev_was_a_at;
  logic                loop_hit;

  // A taken jump back onto the A-instruction just before it is a "@x; 0;JMP" spin.
  always_comb begin
    loop_hit = is_c & take & prev_was_a_vld
             & (pc_nxt == pc_q - PC_ONE)
             & (prev_was_a_at == pc_q - PC_ONE);
  end

  // Remember where the last committed A-instruction lived; latch halt until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_was_a_vld <= 1'b0;
      prev_was_a_at  <= RST_PC;
      halt_q         <= 1'b0;
    end else if (commit) begin
      if (!is_c) begin
        prev_was_a_vld <= 1'b1;
        prev_was_a_at  <= pc_q;
      end
      if (loop_hit) halt_q <= 1'b1;
    end
  end
`else
  assign halt_q = 1'b0;
`endif

  // Outputs.
  always_comb begin
    bus.pc       = pc_q;
    bus.addressM = a_q[PC_WIDTH-1:0];
    bus.outM     = alu_out;
    bus.writeM   = wr_stb;
    bus.readM    = rd_stb;
    a_reg        = a_q;
    d_reg        = d_q;
    halted       = halt_q;
  end
endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: ROM/RAM models, write scoreboard, state checks.
// Latency: drives inputs on the falling edge, samples 1 ns later, commits on the rising edge.
// Backpressure: mem_ready and ce are driven directly to exercise stalls and freezes.
module tb_hack_cpu;
  logic        clk;
  logic        reset_n;
  logic        ce;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] rom [0:63];
  logic [15:0] ram [0:1023];

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t wr_q[$];

  typedef struct {
    logic [15:0] d;
    logic [15:0] op;
    int          pc;
  } jt_t;
  jt_t jt [5];

  hack_cpu_if #(.PC_WIDTH(15)) bus ();

  hack_cpu #(.PC_WIDTH(15), .RESET_PC(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus),
    .a_reg   (a_reg),
    .d_reg   (d_reg),
    .halted  (halted)
  );

  assign bus.instr = rom[bus.pc[5:0]];
  assign bus.inM   = ram[bus.addressM[9:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
  endtask

  // Hold reset for one cycle, then release on a falling edge.
  task automatic restart();
    reset_n = 1'b0;
    ce = 1'b1;
    bus.mem_ready = 1'b1;
    wr_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One cycle; any write committing on this edge is matched against the scoreboard.
  task automatic step();
    logic        do_wr;
    logic [14:0] wa;
    logic [15:0] wd;
    wr_t         e;
    #1;
    do_wr = bus.writeM && bus.mem_ready;
    wa = bus.addressM;
    wd = bus.outM;
    if (do_wr) begin
      chk("wr_expected", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(wa), 32'(e.addr));
        chk("wr_data", 32'(wd), 32'(e.data));
      end
    end
    @(posedge clk);
    if (do_wr) ram[wa[9:0]] = wd;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b0;
    ce = 1'b1;
    bus.mem_ready = 1'b1;
    clear_mem();

    // Reset state; a store sits at pc 0 but the strobe must be forced low.
    rom[0] = 16'hE308;
    @(negedge clk);
    #1;
    chk("rst_a", 32'(a_reg), 32'h0);
    chk("rst_d", 32'(d_reg), 32'h0);
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_writeM", 32'(bus.writeM), 32'h0);
    chk("rst_readM", 32'(bus.readM), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // Load: @5; D=A.
    clear_mem();
    rom[0] = 16'h0005;
    rom[1] = 16'hEC10;
    restart();
    steps(2);
    chk("load_a", 32'(a_reg), 32'd5);
    chk("load_d", 32'(d_reg), 32'd5);
    chk("load_pc", 32'(bus.pc), 32'd2);

    // Write: @100; M=D.
    rom[2] = 16'h0064;
    rom[3] = 16'hE308;
    step();
    #1;
    chk("wr_strobe", 32'(bus.writeM), 32'd1);
    chk("wr_addressM", 32'(bus.addressM), 32'd100);
    chk("wr_outM", 32'(bus.outM), 32'd5);
    wr_q.push_back('{addr: 15'd100, data: 16'd5});
    step();
    chk("wr_pc", 32'(bus.pc), 32'd4);
    chk("wr_ram", 32'(ram[100]), 32'd5);
    chk("wr_drained", 32'(wr_q.size()), 32'd0);

    // Write stall: three cycles of mem_ready=0 then one commit.
    restart();
    steps(3);
    bus.mem_ready = 1'b0;
    wr_q.push_back('{addr: 15'd100, data: 16'd5});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_writeM", 32'(bus.writeM), 32'd1);
      chk("stall_pc", 32'(bus.pc), 32'd3);
      chk("stall_a", 32'(a_reg), 32'd100);
      chk("stall_d", 32'(d_reg), 32'd5);
    end
    bus.mem_ready = 1'b1;
    step();
    chk("stall_commit_pc", 32'(bus.pc), 32'd4);
    chk("stall_drained", 32'(wr_q.size()), 32'd0);

    // Read stall: @100; D=M with M=0x00AB.
    clear_mem();
    ram[100] = 16'h00AB;
    rom[0] = 16'h0064;
    rom[1] = 16'hFC10;
    restart();
    step();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rstall_readM", 32'(bus.readM), 32'd1);
      chk("rstall_d", 32'(d_reg), 32'd0);
      chk("rstall_pc", 32'(bus.pc), 32'd1);
    end
    bus.mem_ready = 1'b1;
    step();
    chk("read_d", 32'(d_reg), 32'h00AB);
    chk("read_pc", 32'(bus.pc), 32'd2);

    // Conditional jumps: @d; D=A; @10; D;Jxx.
    jt[0] = '{d: 16'd0, op: 16'hE302, pc: 10};
    jt[1] = '{d: 16'd3, op: 16'hE302, pc: 4};
    jt[2] = '{d: 16'd3, op: 16'hE301, pc: 10};
    jt[3] = '{d: 16'd3, op: 16'hE304, pc: 4};
    jt[4] = '{d: 16'd3, op: 16'hE305, pc: 10};
    for (int i = 0; i < 5; i++) begin
      clear_mem();
      rom[0] = jt[i].d;
      rom[1] = 16'hEC10;
      rom[2] = 16'h000A;
      rom[3] = jt[i].op;
      restart();
      steps(4);
      chk($sformatf("jmp%0d_pc", i), 32'(bus.pc), 32'(jt[i].pc));
    end

    // A=D;JMP jumps to the old A, not the freshly written one.
    clear_mem();
    rom[0] = 16'h0009;
    rom[1] = 16'hEC10;
    rom[2] = 16'h000C;
    rom[3] = 16'hE327;
    restart();
    steps(4);
    chk("oldA_pc", 32'(bus.pc), 32'd12);
    chk("oldA_a", 32'(a_reg), 32'd9);

    // ce=0 freezes everything and masks the write strobe.
    clear_mem();
    rom[0] = 16'h0005;
    rom[1] = 16'hEC10;
    rom[2] = 16'h0064;
    rom[3] = 16'hE308;
    restart();
    steps(3);
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ce_writeM", 32'(bus.writeM), 32'd0);
      chk("ce_pc", 32'(bus.pc), 32'd3);
      chk("ce_a", 32'(a_reg), 32'd100);
    end
    ce = 1'b1;
    wr_q.push_back('{addr: 15'd100, data: 16'd5});
    step();
    chk("ce_resume_pc", 32'(bus.pc), 32'd4);

    // pc wraps from 32767 to 0.
    clear_mem();
    rom[0]  = 16'h7FFF;
    rom[1]  = 16'hEA87;
    rom[63] = 16'h0001;
    restart();
    steps(2);
    chk("wrap_top", 32'(bus.pc), 32'h7FFF);
    step();
    chk("wrap_pc", 32'(bus.pc), 32'd0);
    chk("wrap_a", 32'(a_reg), 32'd1);

    // Asynchronous reset mid-run with a store pending at pc 20.
    clear_mem();
    rom[0]  = 16'h1234;
    rom[1]  = 16'hEC10;
    rom[2]  = 16'h0014;
    rom[3]  = 16'hE327;
    rom[20] = 16'hE308;
    restart();
    steps(4);
    chk("mid_pc", 32'(bus.pc), 32'd20);
    chk("mid_a", 32'(a_reg), 32'h1234);
    chk("mid_writeM", 32'(bus.writeM), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_a", 32'(a_reg), 32'h0);
    chk("arst_d", 32'(d_reg), 32'h0);
    chk("arst_pc", 32'(bus.pc), 32'h0);
    chk("arst_writeM", 32'(bus.writeM), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("resume_pc", 32'(bus.pc), 32'd1);
    chk("resume_a", 32'(a_reg), 32'h1234);

    // Tight loop: @7 at pc 7, 0;JMP at pc 8.
    clear_mem();
    rom[0] = 16'h0007;
    rom[1] = 16'hEA87;
    rom[7] = 16'h0007;
    rom[8] = 16'hEA87;
    restart();
    steps(3);
    chk("loop_pc8", 32'(bus.pc), 32'd8);
    step();
    chk("loop_back_pc", 32'(bus.pc), 32'd7);
`ifdef HACK_HALT_DETECT_EN
    chk("halt_set", 32'(halted), 32'd1);
    steps(2);
    chk("halt_pc", 32'(bus.pc), 32'd7);
    chk("halt_hold", 32'(halted), 32'd1);
`else
    chk("halt_off", 32'(halted), 32'd0);
    step();
    chk("loop_pc_alt", 32'(bus.pc), 32'd8);
    chk("halt_off_run", 32'(halted), 32'd0);
`endif

    chk("sb_empty", 32'(wr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
